// File: rtl/ttl_74193_sequencer_if.sv
// Command handshake between the microsequencer (master) and the 74193 sequencer (slave).
interface ttl_74193_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ttl_74193_sequencer.sv
// Drives a 74193-style up/down counter with timed control pulses and verifies its
// outputs against a shadow count after each command.
module ttl_74193_sequencer #(
  parameter int WIDTH         = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  MR_bar,
  ttl_74193_sequencer_if.slave  cmd,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      count,
  output logic                  CPU,
  output logic                  CPD,
  output logic                  PL_bar,
  output logic                  MR,
  output logic [WIDTH-1:0]      D,
  input  logic [WIDTH-1:0]      Q
);
  localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_PULSE  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ASSERT,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             ready_nxt, done_nxt, err_nxt;
  logic             cpu_nxt, cpd_nxt, pl_bar_nxt, mr_nxt;
  logic [WIDTH-1:0] count_nxt, d_nxt;

  // Every output is a register so the counter chips never see combinational glitches.
  always_ff @(posedge CLK or negedge MR_bar) begin
    if (!MR_bar) begin
      state         <= S_INIT;
      timer         <= T_PULSE;
      cmd.cmd_ready <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      count         <= '0;
      CPU           <= 1'b1;
      CPD           <= 1'b1;
      PL_bar        <= 1'b1;
      MR            <= 1'b1;
      D             <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      cmd.cmd_ready <= ready_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
      count         <= count_nxt;
      CPU           <= cpu_nxt;
      CPD           <= cpd_nxt;
      PL_bar        <= pl_bar_nxt;
      MR            <= mr_nxt;
      D             <= d_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    ready_nxt  = cmd.cmd_ready;
    done_nxt   = 1'b0;
    err_nxt    = err;
    count_nxt  = count;
    cpu_nxt    = CPU;
    cpd_nxt    = CPD;
    pl_bar_nxt = PL_bar;
    mr_nxt     = MR;
    d_nxt      = D;

    case (state)
      S_INIT: begin
        if (timer == '0) begin
          state_nxt = S_SETTLE;
          timer_nxt = T_SETTLE;
          mr_nxt    = 1'b0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          state_nxt = S_ASSERT;
          timer_nxt = T_PULSE;
          ready_nxt = 1'b0;
          // Shadow count moves at accept; the counter catches up when the pulse releases.
          case (cmd.cmd_op)
            OP_UP: begin
              cpu_nxt   = 1'b0;
              count_nxt = count + 1'b1;
            end
            OP_DOWN: begin
              cpd_nxt   = 1'b0;
              count_nxt = count - 1'b1;
            end
            OP_LOAD: begin
              pl_bar_nxt = 1'b0;
              d_nxt      = cmd.cmd_data;
              count_nxt  = cmd.cmd_data;
            end
            default: begin
              mr_nxt    = 1'b1;
              count_nxt = '0;
              err_nxt   = 1'b0;
            end
          endcase
        end
      end
      S_ASSERT: begin
        if (timer == '0) begin
          state_nxt  = S_SETTLE;
          timer_nxt  = T_SETTLE;
          cpu_nxt    = 1'b1;
          cpd_nxt    = 1'b1;
          pl_bar_nxt = 1'b1;
          mr_nxt     = 1'b0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer == '0) begin
          state_nxt = S_CHECK;
          done_nxt  = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
        if (Q != count) err_nxt = 1'b1;
      end
      default: begin
        state_nxt = S_INIT;
        timer_nxt = T_PULSE;
        mr_nxt    = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_ttl_74193_sequencer.sv
// Bench for ttl_74193_sequencer with a behavioural 74193 on the Q loopback.
module tb_ttl_74193_sequencer;
  localparam int WIDTH  = 4;
  localparam int PULSE  = 2;
  localparam int SETTLE = 2;
  localparam logic [1:0] OP_UP = 2'b00, OP_DOWN = 2'b01, OP_LOAD = 2'b10, OP_CLEAR = 2'b11;

  logic             CLK = 1'b0;
  logic             MR_bar = 1'b0;
  logic             done, err, CPU, CPD, PL_bar, MR;
  logic [WIDTH-1:0] count, D, Q;

  int checks = 0;
  int failures = 0;
  int both_low = 0;
  int multi_active = 0;

  ttl_74193_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  ttl_74193_sequencer #(.WIDTH(WIDTH), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .MR_bar(MR_bar), .cmd(ifc), .done(done), .err(err), .count(count),
    .CPU(CPU), .CPD(CPD), .PL_bar(PL_bar), .MR(MR), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural 74193: MR clears, PL_bar loads, rising CPU/CPD step the count.
  logic [WIDTH-1:0] q_model = '0;
  logic cpu_prev = 1'b1, cpd_prev = 1'b1;
  logic stuck = 1'b0;
  always @(MR or PL_bar or CPU or CPD or D) begin
    if (MR === 1'b1) q_model = '0;
    else if (PL_bar === 1'b0) q_model = D;
    else begin
      if (CPU === 1'b1 && cpu_prev === 1'b0) q_model = q_model + 1'b1;
      if (CPD === 1'b1 && cpd_prev === 1'b0) q_model = q_model - 1'b1;
    end
    cpu_prev = CPU;
    cpd_prev = CPD;
  end
  assign Q = stuck ? '0 : q_model;

  always @(negedge CLK) begin
    if (CPU === 1'b0 && CPD === 1'b0) both_low++;
    if ((int'(CPU === 1'b0) + int'(CPD === 1'b0) + int'(PL_bar === 1'b0) + int'(MR === 1'b1)) > 1)
      multi_active++;
  end

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp_count;
    logic             exp_err;
  } vec_t;
  vec_t vecs[12];

  logic [WIDTH-1:0] exp_cnt;
  logic [WIDTH-1:0] exp_d;
  logic             exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic ctrl_active(input logic [1:0] op);
    case (op)
      OP_UP:   return CPU === 1'b0;
      OP_DOWN: return CPD === 1'b0;
      OP_LOAD: return PL_bar === 1'b0;
      default: return MR === 1'b1;
    endcase
  endfunction

  // Counter value after a command, from the command rules in plain modular arithmetic.
  function automatic logic [WIDTH-1:0] model_next(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] cur);
    int m;
    m = 1 << WIDTH;
    case (op)
      OP_UP:   return WIDTH'((int'(cur) + 1) % m);
      OP_DOWN: return WIDTH'((int'(cur) + m - 1) % m);
      OP_LOAD: return data;
      default: return '0;
    endcase
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) chk("ready_timeout", {31'b0, ifc.cmd_ready}, 1);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
    int n, pw, lat;
    wait_ready(n);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_data  = data;
    @(posedge CLK);
    #1;
    ifc.cmd_valid = 1'b0;
    pw  = 0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (ctrl_active(op)) pw++;
      tick();
      lat++;
    end
    chk("pulse_width", pw, PULSE);
    chk("accept_to_done", lat, PULSE + SETTLE);
    tick();
    chk("done_one_cycle", {31'b0, done}, 0);
    chk("ready_after_check", {31'b0, ifc.cmd_ready}, 1);
  endtask

  initial begin
    int n, acc, exp_acc, period;
    logic [1:0] rop;
    logic [WIDTH-1:0] rdata;

    vecs[0]  = '{OP_UP,    4'h0, 4'h1, 1'b0};
    vecs[1]  = '{OP_UP,    4'h0, 4'h2, 1'b0};
    vecs[2]  = '{OP_UP,    4'h0, 4'h3, 1'b0};
    vecs[3]  = '{OP_LOAD,  4'hE, 4'hE, 1'b0};
    vecs[4]  = '{OP_UP,    4'h0, 4'hF, 1'b0};
    vecs[5]  = '{OP_UP,    4'h0, 4'h0, 1'b0};
    vecs[6]  = '{OP_DOWN,  4'h0, 4'hF, 1'b0};
    vecs[7]  = '{OP_DOWN,  4'h0, 4'hE, 1'b0};
    vecs[8]  = '{OP_LOAD,  4'h5, 4'h5, 1'b0};
    vecs[9]  = '{OP_CLEAR, 4'h9, 4'h0, 1'b0};
    vecs[10] = '{OP_DOWN,  4'h0, 4'hF, 1'b0};
    vecs[11] = '{OP_LOAD,  4'h3, 4'h3, 1'b0};

    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = OP_UP;
    ifc.cmd_data  = '0;

    // Reset state
    #12;
    chk("rst_mr", {31'b0, MR}, 1);
    chk("rst_cpu_cpd_pl", {29'b0, CPU, CPD, PL_bar}, 3'b111);
    chk("rst_count", {28'b0, count}, 0);
    chk("rst_d", {28'b0, D}, 0);
    chk("rst_err_done_ready", {29'b0, err, done, ifc.cmd_ready}, 0);
    @(posedge CLK);
    #1;
    MR_bar = 1'b1;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
      if (n == 1) chk("init_mr_held", {31'b0, MR}, 1);
    end
    chk("init_to_ready", n, PULSE + SETTLE + 1);
    chk("init_err", {31'b0, err}, 0);
    chk("init_q", {28'b0, Q}, 0);

    // Table-driven directed commands
    exp_d = '0;
    for (int i = 0; i < 12; i++) begin
      send_cmd(vecs[i].op, vecs[i].data);
      if (vecs[i].op == OP_LOAD) exp_d = vecs[i].data;
      chk($sformatf("vec%0d_count", i), {28'b0, count}, {28'b0, vecs[i].exp_count});
      chk($sformatf("vec%0d_q", i), {28'b0, Q}, {28'b0, vecs[i].exp_count});
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_d", i), {28'b0, D}, {28'b0, exp_d});
    end
    exp_cnt = 4'h3;

    // Counter output stuck at 0: error is sticky until a CLEAR
    stuck = 1'b1;
    send_cmd(OP_UP, '0);
    chk("stuck_count", {28'b0, count}, 4);
    chk("stuck_err_set", {31'b0, err}, 1);
    send_cmd(OP_UP, '0);
    chk("stuck_err_sticky", {31'b0, err}, 1);
    send_cmd(OP_CLEAR, '0);
    chk("clear_err", {31'b0, err}, 0);
    chk("clear_count", {28'b0, count}, 0);
    stuck = 1'b0;
    chk("clear_q", {28'b0, Q}, 0);
    exp_cnt = '0;

    // Randomized commands against the arithmetic model
    exp_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom_range(0, 3));
      rdata = WIDTH'($urandom_range(0, 15));
      send_cmd(rop, rdata);
      exp_cnt = model_next(rop, rdata, exp_cnt);
      if (rop == OP_LOAD) exp_d = rdata;
      chk("rand_count", {28'b0, count}, {28'b0, exp_cnt});
      chk("rand_q", {28'b0, Q}, {28'b0, exp_cnt});
      chk("rand_d", {28'b0, D}, {28'b0, exp_d});
      chk("rand_err", {31'b0, err}, {31'b0, exp_err});
    end

    // cmd_valid held high: accepts only happen in IDLE, one per full command cycle
    wait_ready(n);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = OP_UP;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ifc.cmd_valid === 1'b1 && ifc.cmd_ready === 1'b1) acc++;
      @(posedge CLK);
      #1;
    end
    ifc.cmd_valid = 1'b0;
    period  = PULSE + SETTLE + 2;
    exp_acc = (20 + period - 1) / period;
    chk("held_valid_accepts", acc, exp_acc);
    wait_ready(n);
    exp_cnt = WIDTH'((int'(exp_cnt) + acc) % (1 << WIDTH));
    chk("held_valid_count", {28'b0, count}, {28'b0, exp_cnt});
    chk("held_valid_q", {28'b0, Q}, {28'b0, exp_cnt});

    // Reset in the middle of a DOWN pulse
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = OP_DOWN;
    @(posedge CLK);
    #1;
    ifc.cmd_valid = 1'b0;
    chk("abort_cpd_active", {31'b0, CPD}, 0);
    #3;
    MR_bar = 1'b0;
    #1;
    chk("abort_cpd_high", {31'b0, CPD}, 1);
    chk("abort_mr", {31'b0, MR}, 1);
    chk("abort_count", {28'b0, count}, 0);
    @(posedge CLK);
    #1;
    MR_bar = 1'b1;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("abort_init_to_ready", n, PULSE + SETTLE + 1);
    chk("abort_final_count", {28'b0, count}, 0);
    chk("abort_final_q", {28'b0, Q}, 0);
    chk("abort_final_err", {31'b0, err}, 0);

    chk("never_both_low", both_low, 0);
    chk("single_control_active", multi_active, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
